// File: rtl/preg_free_list_pkg.sv
// Shared sizing for the physical-register free list: tag width, list depth and counter widths.
package preg_free_list_pkg;

    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int PREG_W    = $clog2(NUM_PREGS);
    localparam int DEPTH     = NUM_PREGS - NUM_AREGS;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(DEPTH + 1);

    typedef logic [PREG_W-1:0] preg_tag_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;
    typedef logic [CNT_W-1:0]  fl_cnt_t;

endpackage

// File: rtl/preg_free_list_if.sv
// Rename-side allocate and commit-side free signals of the free list.
interface preg_free_list_if;
    import preg_free_list_pkg::*;

    logic      alloc_req;
    logic      alloc_ok;
    preg_tag_t alloc_tag;
    logic      stall_out;
    logic      free_valid;
    preg_tag_t free_tag;
    fl_cnt_t   free_count;
    logic      free_err;

    modport master (
        output alloc_req, free_valid, free_tag,
        input  alloc_ok, alloc_tag, stall_out, free_count, free_err
    );

    modport slave (
        input  alloc_req, free_valid, free_tag,
        output alloc_ok, alloc_tag, stall_out, free_count, free_err
    );

endinterface

// File: rtl/preg_free_list_fifo.sv
// Circular buffer of free tags. Reset preloads entry i with tag NUM_AREGS+i, so the
// list starts full. The parent guarantees pop only when non-empty and push only when not full.
module preg_fifo
    import preg_free_list_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  preg_tag_t push_tag_i,
    input  logic      pop_i,
    output preg_tag_t head_tag_o,
    output fl_cnt_t   count_o
);

    preg_tag_t mem_q [DEPTH];
    fl_ptr_t   head_q, head_d;
    fl_ptr_t   tail_q, tail_d;
    fl_cnt_t   count_q, count_d;

    // Pointer and occupancy next-state; pointers wrap by natural overflow.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_i) begin
            head_d = head_q + fl_ptr_t'(1);
        end
        if (push_i) begin
            tail_d = tail_q + fl_ptr_t'(1);
        end
        count_d = count_q + fl_cnt_t'(push_i) - fl_cnt_t'(pop_i);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= fl_cnt_t'(DEPTH);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage, preloaded with the tags not mapped at reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= preg_tag_t'(NUM_AREGS + i);
            end
        end else if (push_i) begin
            mem_q[tail_q] <= push_tag_i;
        end
    end

    assign head_tag_o = mem_q[head_q];
    assign count_o    = count_q;

endmodule

// File: rtl/preg_free_list.sv
// Physical-register free list: show-ahead allocate to rename, checked free from commit.
// The bitmap mirrors list membership so double-frees are caught without searching the FIFO.
module preg_free_list
    import preg_free_list_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    preg_free_list_if.slave  fl
);

    logic [NUM_PREGS-1:0] bitmap_q, bitmap_d;
    logic                 free_err_q, free_err_d;
    preg_tag_t            head_tag_w;
    fl_cnt_t              count_w;
    fl_cnt_t              count_after_pop_w;
    logic                 alloc_ok_w;
    logic                 pop_w;
    logic                 push_w;

    assign alloc_ok_w        = (count_w != '0);
    assign pop_w             = fl.alloc_req && alloc_ok_w;
    assign count_after_pop_w = count_w - fl_cnt_t'(pop_w);

    // A free is accepted only for a non-zero tag that is currently allocated and
    // only if the list has room once this cycle's pop is accounted for. Legality
    // uses the registered bitmap, so there is no same-cycle bypass of the pop.
    assign push_w = fl.free_valid
                 && (fl.free_tag != '0)
                 && !bitmap_q[fl.free_tag]
                 && (count_after_pop_w < fl_cnt_t'(DEPTH));

    preg_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_w),
        .push_tag_i (fl.free_tag),
        .pop_i      (pop_w),
        .head_tag_o (head_tag_w),
        .count_o    (count_w)
    );

    // Membership bitmap and sticky error next-state.
    always_comb begin
        bitmap_d   = bitmap_q;
        free_err_d = free_err_q;
        if (pop_w) begin
            bitmap_d[head_tag_w] = 1'b0;
        end
        if (push_w) begin
            bitmap_d[fl.free_tag] = 1'b1;
        end
        if (fl.free_valid && !push_w) begin
            free_err_d = 1'b1;
        end
    end

    // Bitmap and error registers; tags above the architectural range start free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap_q   <= {{DEPTH{1'b1}}, {NUM_AREGS{1'b0}}};
            free_err_q <= 1'b0;
        end else begin
            bitmap_q   <= bitmap_d;
            free_err_q <= free_err_d;
        end
    end

    assign fl.alloc_ok   = alloc_ok_w;
    assign fl.alloc_tag  = head_tag_w;
    assign fl.stall_out  = !alloc_ok_w;
    assign fl.free_count = count_w;
    assign fl.free_err   = free_err_q;

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: drives and samples on the falling edge.
module tb_preg_free_list;
    import preg_free_list_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   free_q[$];
    int   inuse_q[$];

    preg_free_list_if fl_if ();

    preg_free_list dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fl    (fl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        fl_if.alloc_req  = 1'b0;
        fl_if.free_valid = 1'b0;
        fl_if.free_tag   = '0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle();
        rst_n = 1'b0;
        #12;

        // 1: reset state
        check("rst_tag",   int'(fl_if.alloc_tag),  32);
        check("rst_ok",    int'(fl_if.alloc_ok),   1);
        check("rst_stall", int'(fl_if.stall_out),  0);
        check("rst_count", int'(fl_if.free_count), 32);
        check("rst_err",   int'(fl_if.free_err),   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_tag", int'(fl_if.alloc_tag), 32);

        // 2: drain all 32 tags in order
        for (int i = 0; i < DEPTH; i++) begin
            fl_if.alloc_req = 1'b1;
            check("drain_tag", int'(fl_if.alloc_tag), 32 + i);
            check("drain_ok",  int'(fl_if.alloc_ok),  1);
            @(negedge clk);
        end
        check("empty_ok",    int'(fl_if.alloc_ok),   0);
        check("empty_stall", int'(fl_if.stall_out),  1);
        check("empty_count", int'(fl_if.free_count), 0);
        @(negedge clk);
        check("extra_req_count", int'(fl_if.free_count), 0);
        check("extra_req_err",   int'(fl_if.free_err),   0);

        // 3: free into empty list with alloc pending, no bypass
        fl_if.free_valid = 1'b1;
        fl_if.free_tag   = preg_tag_t'(40);
        #1;
        check("nobypass_ok", int'(fl_if.alloc_ok), 0);
        @(negedge clk);
        idle();
        check("refill_tag",   int'(fl_if.alloc_tag),  40);
        check("refill_ok",    int'(fl_if.alloc_ok),   1);
        check("refill_count", int'(fl_if.free_count), 1);
        check("refill_err",   int'(fl_if.free_err),   0);

        // 4: illegal frees
        fl_if.free_valid = 1'b1;
        fl_if.free_tag   = '0;
        @(negedge clk);
        idle();
        check("p0_err",   int'(fl_if.free_err),   1);
        check("p0_count", int'(fl_if.free_count), 1);
        fl_if.free_valid = 1'b1;
        fl_if.free_tag   = preg_tag_t'(50);
        @(negedge clk);
        check("free50_count", int'(fl_if.free_count), 2);
        @(negedge clk);
        idle();
        check("dbl50_count", int'(fl_if.free_count), 2);
        check("dbl50_tag",   int'(fl_if.alloc_tag),  40);

        // 5: steady alloc+free; model the list and the set of allocated tags
        free_q = '{40, 50};
        for (int t = 32; t < 64; t++) begin
            if (t != 40 && t != 50) inuse_q.push_back(t);
        end
        for (int i = 0; i < 100; i++) begin
            int exp_tag;
            int ret_tag;
            exp_tag = free_q.pop_front();
            ret_tag = inuse_q.pop_front();
            fl_if.alloc_req  = 1'b1;
            fl_if.free_valid = 1'b1;
            fl_if.free_tag   = preg_tag_t'(ret_tag);
            check("steady_tag", int'(fl_if.alloc_tag), exp_tag);
            free_q.push_back(ret_tag);
            inuse_q.push_back(exp_tag);
            @(negedge clk);
            check("steady_count", int'(fl_if.free_count), 2);
        end
        idle();

        // 6: build count=5, then async reset mid-stream
        for (int i = 0; i < 3; i++) begin
            fl_if.free_valid = 1'b1;
            fl_if.free_tag   = preg_tag_t'(inuse_q.pop_front());
            @(negedge clk);
        end
        idle();
        check("pre_rst_count", int'(fl_if.free_count), 5);
        check("pre_rst_tag",   int'(fl_if.alloc_tag),  free_q[0]);
        fl_if.alloc_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tag",   int'(fl_if.alloc_tag),  32);
        check("arst_ok",    int'(fl_if.alloc_ok),   1);
        check("arst_stall", int'(fl_if.stall_out),  0);
        check("arst_count", int'(fl_if.free_count), 32);
        check("arst_err",   int'(fl_if.free_err),   0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        fl_if.alloc_req = 1'b1;
        @(negedge clk);
        idle();
        check("post_rst_tag",   int'(fl_if.alloc_tag),  33);
        check("post_rst_count", int'(fl_if.free_count), 31);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
